// File: rtl/spram_arb_pkg.sv
// ---------------------------------------------------------------------------
// spram_arb_pkg : shared encodings for the two-port SPRAM arbiter. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic logic [1:0] sel_onehot(input logic sel);
    return (sel == SEL_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spram_arbiter_rr_grant2.sv
// ---------------------------------------------------------------------------
// rr_grant2 : two-requester round-robin grant with lock override. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_grant2
  import spram_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic [1:0] i_lock,
  output logic [1:0] o_grant,
  output owner_e     o_owner
);

  logic   ptr_q, ptr_d;
  owner_e owner_q, owner_d;
  logic [1:0] grant;

  // A lock owner shuts the other side out even while it idles.
  always_comb begin
    grant = 2'b00;
    case (owner_q)
      OWN_A:   grant = {1'b0, i_req[0]};
      OWN_B:   grant = {i_req[1], 1'b0};
      default: grant = (&i_req) ? sel_onehot(ptr_q) : i_req;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (grant[0]) begin
      ptr_d = SEL_B;
      if (i_lock[0])
        owner_d = OWN_A;
      else if (owner_q == OWN_A)
        owner_d = OWN_NONE;
    end else if (grant[1]) begin
      ptr_d = SEL_A;
      if (i_lock[1])
        owner_d = OWN_B;
      else if (owner_q == OWN_B)
        owner_d = OWN_NONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q   <= SEL_A;
      owner_q <= OWN_NONE;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign o_grant = grant;
  assign o_owner = owner_q;

endmodule

`default_nettype wire

// File: rtl/spram_arbiter.sv
// ---------------------------------------------------------------------------
// spram_arbiter : shares one 1-cycle-latency SPRAM between ports A and B. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int ADDR_SZ = 14,
  parameter int DATA_SZ = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_a_req,
  input  logic               i_a_wr,
  input  logic               i_a_lock,
  input  logic [ADDR_SZ-1:0] i_a_addr,
  input  logic [DATA_SZ-1:0] i_a_wdata,
  output logic               o_a_ack,
  output logic               o_a_rvalid,
  output logic [DATA_SZ-1:0] o_a_rdata,
  input  logic               i_b_req,
  input  logic               i_b_wr,
  input  logic               i_b_lock,
  input  logic [ADDR_SZ-1:0] i_b_addr,
  input  logic [DATA_SZ-1:0] i_b_wdata,
  output logic               o_b_ack,
  output logic               o_b_rvalid,
  output logic [DATA_SZ-1:0] o_b_rdata,
  output logic               o_ram_cs,
  output logic               o_ram_we,
  output logic [ADDR_SZ-1:0] o_ram_addr,
  output logic [DATA_SZ-1:0] o_ram_wdata,
  input  logic [DATA_SZ-1:0] i_ram_rdata,
  output logic               o_busy
);

  logic [1:0] req;
  logic [1:0] grant;
  owner_e     owner;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_tag_q, rd_tag_d;
  logic       rd_live;

  // No access is issued while reset is being sampled.
  assign req = {i_b_req, i_a_req} & {2{i_rst_n}};

  rr_grant2 u_grant (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (req),
    .i_lock  ({i_b_lock, i_a_lock}),
    .o_grant (grant),
    .o_owner (owner)
  );

  always_comb begin
    o_ram_cs    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (grant[0]) begin
      o_ram_cs    = 1'b1;
      o_ram_we    = i_a_wr;
      o_ram_addr  = i_a_addr;
      o_ram_wdata = i_a_wdata;
    end else if (grant[1]) begin
      o_ram_cs    = 1'b1;
      o_ram_we    = i_b_wr;
      o_ram_addr  = i_b_addr;
      o_ram_wdata = i_b_wdata;
    end
  end

  assign o_a_ack = grant[0];
  assign o_b_ack = grant[1];

  // Tag only moves on a read, so the return in flight is never retargeted.
  always_comb begin
    rd_valid_d = o_ram_cs & ~o_ram_we;
    rd_tag_d   = rd_tag_q;
    if (rd_valid_d)
      rd_tag_d = grant[1] ? SEL_B : SEL_A;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_valid_q <= 1'b0;
      rd_tag_q   <= SEL_A;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  // A return landing in a reset cycle is dropped.
  assign rd_live    = rd_valid_q & i_rst_n;
  assign o_a_rvalid = rd_live & (rd_tag_q == SEL_A);
  assign o_b_rvalid = rd_live & (rd_tag_q == SEL_B);
  assign o_a_rdata  = i_ram_rdata;
  assign o_b_rdata  = i_ram_rdata;
  assign o_busy     = (owner != OWN_NONE) | rd_live;

endmodule

`default_nettype wire

// File: tb/tb_spram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spram_arbiter : cycle-by-cycle vector bench for spram_arbiter. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_wr, a_lock, b_req, b_wr, b_lock;
  logic [13:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, a_rvalid, b_ack, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        ram_cs, ram_we, busy;
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [15:0] mem [0:16383];

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spram_arbiter #(.ADDR_SZ(14), .DATA_SZ(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a_req), .i_a_wr(a_wr), .i_a_lock(a_lock), .i_a_addr(a_addr),
    .i_a_wdata(a_wdata), .o_a_ack(a_ack), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
    .i_b_req(b_req), .i_b_wr(b_wr), .i_b_lock(b_lock), .i_b_addr(b_addr),
    .i_b_wdata(b_wdata), .o_b_ack(b_ack), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
    .o_ram_cs(ram_cs), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata), .o_busy(busy)
  );

  // SPRAM behavioural model: 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    string       name;
    logic        rst_n;
    logic        ar, aw, al;
    logic [13:0] aa;
    logic [15:0] awd;
    logic        br, bw, bl;
    logic [13:0] ba;
    logic [15:0] bwd;
    logic        e_aack, e_back, e_arv, e_brv;
    logic [15:0] e_rd;
    logic        e_cs, e_we;
    logic [13:0] e_addr;
    logic [15:0] e_wd;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string n, input logic rn,
    input logic ar, input logic aw, input logic al, input logic [13:0] aa, input logic [15:0] awd,
    input logic br, input logic bw, input logic bl, input logic [13:0] ba, input logic [15:0] bwd,
    input logic eaa, input logic eba, input logic earv, input logic ebrv, input logic [15:0] erd,
    input logic ecs, input logic ewe, input logic [13:0] eadr, input logic [15:0] ewd, input logic ebusy);
    vec_t v;
    v.name = n; v.rst_n = rn;
    v.ar = ar; v.aw = aw; v.al = al; v.aa = aa; v.awd = awd;
    v.br = br; v.bw = bw; v.bl = bl; v.ba = ba; v.bwd = bwd;
    v.e_aack = eaa; v.e_back = eba; v.e_arv = earv; v.e_brv = ebrv; v.e_rd = erd;
    v.e_cs = ecs; v.e_we = ewe; v.e_addr = eadr; v.e_wd = ewd; v.e_busy = ebusy;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_n = v.rst_n;
    a_req = v.ar; a_wr = v.aw; a_lock = v.al; a_addr = v.aa; a_wdata = v.awd;
    b_req = v.br; b_wr = v.bw; b_lock = v.bl; b_addr = v.ba; b_wdata = v.bwd;
  endtask

  task automatic apply(input vec_t v);
    logic bad;
    @(negedge clk);
    drive(v);
    #1;
    n_vec++;
    bad = (a_ack !== v.e_aack) || (b_ack !== v.e_back) || (a_rvalid !== v.e_arv) ||
          (b_rvalid !== v.e_brv) || (ram_cs !== v.e_cs) || (ram_we !== v.e_we) ||
          (ram_addr !== v.e_addr) || (ram_wdata !== v.e_wd) || (busy !== v.e_busy) ||
          (v.e_arv && (a_rdata !== v.e_rd)) || (v.e_brv && (b_rdata !== v.e_rd));
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got ack=%b%b rv=%b%b cs=%b we=%b addr=%h wd=%h busy=%b rd=%h/%h; want ack=%b%b rv=%b%b cs=%b we=%b addr=%h wd=%h busy=%b rd=%h",
               v.name, a_ack, b_ack, a_rvalid, b_rvalid, ram_cs, ram_we, ram_addr, ram_wdata,
               busy, a_rdata, b_rdata, v.e_aack, v.e_back, v.e_arv, v.e_brv, v.e_cs, v.e_we,
               v.e_addr, v.e_wd, v.e_busy, v.e_rd);
    end
  endtask

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got;
    mem[14'h0020] = 16'hBEEF;
    mem[14'h0001] = 16'h1111;
    mem[14'h0002] = 16'h2222;
    mem[14'h0003] = 16'h3333;
    ram_rdata = '0;
    drive(mk("init", 1'b0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0));
    repeat (2) @(posedge clk);

    //                  name          rst  A: req wr lk addr   wdata    B: req wr lk addr   wdata    aack back arv brv rdata     cs we addr   wdata    busy
    vecs.push_back(mk("reset",        0,   0,0,0,14'h0,  16'h0,   0,0,0,14'h0,  16'h0,   0,0,0,0,16'h0,    0,0,14'h0,  16'h0,   0));
    vecs.push_back(mk("a_write",      1,   1,1,0,14'h10, 16'h1234,0,0,0,14'h0,  16'h0,   1,0,0,0,16'h0,    1,1,14'h10, 16'h1234,0));
    vecs.push_back(mk("wr_no_rv",     1,   0,0,0,14'h0,  16'h0,   0,0,0,14'h0,  16'h0,   0,0,0,0,16'h0,    0,0,14'h0,  16'h0,   0));
    vecs.push_back(mk("reset2",       0,   0,0,0,14'h0,  16'h0,   0,0,0,14'h0,  16'h0,   0,0,0,0,16'h0,    0,0,14'h0,  16'h0,   0));
    vecs.push_back(mk("cont_a1",      1,   1,0,0,14'h10, 16'h0,   1,0,0,14'h20, 16'h0,   1,0,0,0,16'h0,    1,0,14'h10, 16'h0,   0));
    vecs.push_back(mk("cont_b1",      1,   1,0,0,14'h10, 16'h0,   1,0,0,14'h20, 16'h0,   0,1,1,0,16'h1234, 1,0,14'h20, 16'h0,   1));
    vecs.push_back(mk("cont_a2",      1,   1,0,0,14'h10, 16'h0,   1,0,0,14'h20, 16'h0,   1,0,0,1,16'hBEEF, 1,0,14'h10, 16'h0,   1));
    vecs.push_back(mk("cont_b2",      1,   1,0,0,14'h10, 16'h0,   1,0,0,14'h20, 16'h0,   0,1,1,0,16'h1234, 1,0,14'h20, 16'h0,   1));
    vecs.push_back(mk("cont_tail",    1,   0,0,0,14'h0,  16'h0,   0,0,0,14'h0,  16'h0,   0,0,0,1,16'hBEEF, 0,0,14'h0,  16'h0,   1));
    vecs.push_back(mk("cont_idle",    1,   0,0,0,14'h0,  16'h0,   0,0,0,14'h0,  16'h0,   0,0,0,0,16'h0,    0,0,14'h0,  16'h0,   0));
    vecs.push_back(mk("lock_rd",      1,   1,0,1,14'h10, 16'h0,   1,0,0,14'h20, 16'h0,   1,0,0,0,16'h0,    1,0,14'h10, 16'h0,   0));
    vecs.push_back(mk("lock_hold1",   1,   0,0,0,14'h0,  16'h0,   1,0,0,14'h20, 16'h0,   0,0,1,0,16'h1234, 0,0,14'h0,  16'h0,   1));
    vecs.push_back(mk("lock_hold2",   1,   0,0,0,14'h0,  16'h0,   1,0,0,14'h20, 16'h0,   0,0,0,0,16'h0,    0,0,14'h0,  16'h0,   1));
    vecs.push_back(mk("lock_hold3",   1,   0,0,0,14'h0,  16'h0,   1,0,0,14'h20, 16'h0,   0,0,0,0,16'h0,    0,0,14'h0,  16'h0,   1));
    vecs.push_back(mk("unlock_wr",    1,   1,1,0,14'h30, 16'h5555,1,0,0,14'h20, 16'h0,   1,0,0,0,16'h0,    1,1,14'h30, 16'h5555,1));
    vecs.push_back(mk("b_after_unl",  1,   0,0,0,14'h0,  16'h0,   1,0,0,14'h20, 16'h0,   0,1,0,0,16'h0,    1,0,14'h20, 16'h0,   0));
    vecs.push_back(mk("b_rv",         1,   0,0,0,14'h0,  16'h0,   0,0,0,14'h0,  16'h0,   0,0,0,1,16'hBEEF, 0,0,14'h0,  16'h0,   1));
    vecs.push_back(mk("b2b_rd1",      1,   1,0,0,14'h1,  16'h0,   0,0,0,14'h0,  16'h0,   1,0,0,0,16'h0,    1,0,14'h1,  16'h0,   0));
    vecs.push_back(mk("b2b_rd2",      1,   1,0,0,14'h2,  16'h0,   0,0,0,14'h0,  16'h0,   1,0,1,0,16'h1111, 1,0,14'h2,  16'h0,   1));
    vecs.push_back(mk("b2b_rd3",      1,   1,0,0,14'h3,  16'h0,   0,0,0,14'h0,  16'h0,   1,0,1,0,16'h2222, 1,0,14'h3,  16'h0,   1));
    vecs.push_back(mk("b2b_tail",     1,   0,0,0,14'h0,  16'h0,   0,0,0,14'h0,  16'h0,   0,0,1,0,16'h3333, 0,0,14'h0,  16'h0,   1));
    vecs.push_back(mk("b2b_idle",     1,   0,0,0,14'h0,  16'h0,   0,0,0,14'h0,  16'h0,   0,0,0,0,16'h0,    0,0,14'h0,  16'h0,   0));
    vecs.push_back(mk("rst_rd",       1,   1,0,0,14'h10, 16'h0,   0,0,0,14'h0,  16'h0,   1,0,0,0,16'h0,    1,0,14'h10, 16'h0,   0));
    vecs.push_back(mk("rst_drop",     0,   1,0,0,14'h10, 16'h0,   1,0,0,14'h20, 16'h0,   0,0,0,0,16'h0,    0,0,14'h0,  16'h0,   0));
    vecs.push_back(mk("rst_ptr_a",    1,   1,0,0,14'h10, 16'h0,   1,0,0,14'h20, 16'h0,   1,0,0,0,16'h0,    1,0,14'h10, 16'h0,   0));
    vecs.push_back(mk("rst_ptr_rv",   1,   0,0,0,14'h0,  16'h0,   0,0,0,14'h0,  16'h0,   0,0,1,0,16'h1234, 0,0,14'h0,  16'h0,   1));
    vecs.push_back(mk("b_lock_rd",    1,   0,0,0,14'h0,  16'h0,   1,0,1,14'h20, 16'h0,   0,1,0,0,16'h0,    1,0,14'h20, 16'h0,   0));
    vecs.push_back(mk("b_lock_hold",  1,   1,0,0,14'h10, 16'h0,   0,0,0,14'h0,  16'h0,   0,0,0,1,16'hBEEF, 0,0,14'h0,  16'h0,   1));
    vecs.push_back(mk("b_lock_rst",   0,   1,0,0,14'h10, 16'h0,   0,0,0,14'h0,  16'h0,   0,0,0,0,16'h0,    0,0,14'h0,  16'h0,   1));
    vecs.push_back(mk("a_after_rst",  1,   1,0,0,14'h10, 16'h0,   0,0,0,14'h0,  16'h0,   1,0,0,0,16'h0,    1,0,14'h10, 16'h0,   0));
    vecs.push_back(mk("a_after_rv",   1,   0,0,0,14'h0,  16'h0,   0,0,0,14'h0,  16'h0,   0,0,1,0,16'h1234, 0,0,14'h0,  16'h0,   1));
    vecs.push_back(mk("final_idle",   1,   0,0,0,14'h0,  16'h0,   0,0,0,14'h0,  16'h0,   0,0,0,0,16'h0,    0,0,14'h0,  16'h0,   0));

    foreach (vecs[i]) apply(vecs[i]);

    // B writes, then A reads the same word back with bounded handshakes.
    @(negedge clk);
    b_req = 1'b1; b_wr = 1'b1; b_lock = 1'b0; b_addr = 14'h40; b_wdata = 16'hCAFE;
    #1;
    check("seq_b_wr_ack", {30'h0, b_ack, ram_we}, 32'h3);
    @(negedge clk);
    b_req = 1'b0; b_wr = 1'b0;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 14'h40;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      #1;
      if (a_ack) got = 1'b1;
      @(negedge clk);
    end
    check("seq_a_rd_ack", {31'h0, got}, 32'h1);
    a_req = 1'b0;
    #1;
    check("seq_a_rvalid", {31'h0, a_rvalid}, 32'h1);
    check("seq_a_rdata", {16'h0, a_rdata}, {16'h0, 16'hCAFE});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Shares one iCE40 SPRAM block (16K x 16, 1-cycle read latency) between two requesters, port A and port B.
- Round-robin fair arbitration, with an optional per-requester lock for atomic read-modify-write sequences.
- Sits between the SPRAM primitive wrapper and client logic (e.g. the uFork core and a UART loader/debug port).
- Exactly one access is issued per cycle; read data is routed back to the requester that issued it.

Parameters:
- ADDR_SZ, 14, address width in 16-bit words.
- DATA_SZ, 16, data width.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous reset, active-low.
- i_a_req  in  1  A request valid; held until o_a_ack.
- i_a_wr  in  1  A: 1=write, 0=read.
- i_a_lock  in  1  A: keep grant after this access.
- i_a_addr  in  ADDR_SZ  A word address.
- i_a_wdata  in  DATA_SZ  A write data.
- o_a_ack  out  1  A request accepted this cycle.
- o_a_rvalid  out  1  A read data valid.
- o_a_rdata  out  DATA_SZ  A read data.
- i_b_req, i_b_wr, i_b_lock, i_b_addr, i_b_wdata, o_b_ack, o_b_rvalid, o_b_rdata: same as A, for port B.
- o_ram_cs  out  1  SPRAM access strobe.
- o_ram_we  out  1  SPRAM write enable.
- o_ram_addr  out  ADDR_SZ  SPRAM address.
- o_ram_wdata  out  DATA_SZ  SPRAM write data.
- i_ram_rdata  in  DATA_SZ  SPRAM read data, valid the cycle after a read strobe.
- o_busy  out  1  a lock is held or a read is in flight.

Behaviour:
- Reset: i_rst_n=0 sampled at posedge clears all registered state.
  - Outputs after reset: o_*_ack=0, o_*_rvalid=0, o_busy=0, o_ram_cs=0, o_ram_we=0.
  - Priority pointer resets to favour A; lock owner resets to NONE.
  - A read in flight when reset is asserted is discarded (no rvalid).
- Grant is combinational from the current requests and registered state:
  - owner=A: grant A if i_a_req, else no grant (B is blocked).
  - owner=B: symmetric.
  - owner=NONE, one request: grant that requester.
  - owner=NONE, both request: grant the side favoured by the pointer.
- Granted cycle:
  - o_ram_cs=1; o_ram_we/addr/wdata driven from the granted port.
  - o_X_ack=1 for the granted port only.
  - Non-granted ram outputs are 0.
- Handshake: the request is consumed at the posedge where ack=1. The requester may present a new request in the next cycle (back-to-back at 1 access/cycle).
- Pointer update on each grant (registered): favour the other side next. This gives strict alternation under continuous contention.
- Lock, applied at the posedge of an accepted access:
  - i_X_lock=1 sets owner=X.
  - i_X_lock=0 on an access by the owner releases it to NONE.
  - While owner=X, the other side receives no ack regardless of the pointer. X may idle and still hold the lock.
  - Lock change takes effect from the next cycle.
- Read return:
  - A read granted in cycle N gives o_X_rvalid=1 in cycle N+1 for exactly one cycle.
  - o_X_rdata=i_ram_rdata in that cycle; it is a don't-care otherwise but must be driven (pass i_ram_rdata through).
  - Writes never assert rvalid.
  - A tag register records which port issued the read; a new grant in N+1 does not disturb it.
- o_busy = (owner != NONE) | read in flight.
- Simultaneous events:
  - A read return to A and a new grant to B in the same cycle are independent.
  - A lock set and release on the same port in one access is impossible (single bit).

Decomposition:
- Package spram_arb_pkg holds:
  - Owner encoding: OWN_NONE=2'b00, OWN_A=2'b01, OWN_B=2'b10.
  - Port select constant: SEL_A=1'b0, SEL_B=1'b1.
- One natural sub-module, rr_grant2: two-requester round-robin grant with lock override.
  - Inputs: req[1:0], pointer, owner.
  - Output: grant one-hot.
  - Registered pointer and owner update, with synchronous active-low reset.
- The top level adds the datapath mux and the read-return tag pipeline.

Test Plan:
- After reset, A writes 0x1234 @0x0010 while B idle:
  - o_a_ack=1 in the same cycle; o_ram_cs=1, we=1, addr=0x0010, wdata=0x1234.
  - no rvalid follows.
- Continuous contention, A and B both reading @0x0010/@0x0020:
  - acks alternate A,B,A,B starting with A.
  - o_a_rvalid returns 0x1234 one cycle after each A grant; B rvalids carry SPRAM content at 0x0020.
- A issues a read with i_a_lock=1, idles 3 cycles, then writes with lock=0; B requests throughout:
  - B receives no ack until the cycle after A's unlocking write; o_busy=1 throughout the lock.
- Back-to-back A reads @1,@2,@3 with B idle:
  - ack on 3 consecutive cycles; rvalid on the 3 following cycles with data in address order.
- A read granted in cycle N, i_rst_n=0 in cycle N+1:
  - o_a_rvalid stays 0; owner=NONE; the next contention grants A first.
- B holds the lock; A requests; reset is asserted:
  - after reset, A is acked on the first request cycle.
